// File: rtl/pic_pkg.sv
// pic_pkg: shared states, command bit positions and OCW2 codes for the PIC sequencer
package pic_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY} state_t;
  localparam int unsigned IC4_BIT  = 0;
  localparam int unsigned SNGL_BIT = 1;
  localparam int unsigned LTIM_BIT = 3;
  localparam int unsigned ICW1_BIT = 4;
  localparam int unsigned AEOI_BIT = 1;
  localparam int unsigned RIS_BIT  = 0;
  localparam int unsigned RR_BIT   = 1;
  localparam int unsigned P_BIT    = 2;
  localparam int unsigned SMM_BIT  = 5;
  localparam int unsigned ESMM_BIT = 6;
  localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] EOI_NS       = 3'b001;
  localparam logic [2:0] OCW2_NOP     = 3'b010;
  localparam logic [2:0] EOI_SP       = 3'b011;
  localparam logic [2:0] ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] ROT_EOI_NS   = 3'b101;
  localparam logic [2:0] SET_PRI      = 3'b110;
  localparam logic [2:0] ROT_EOI_SP   = 3'b111;
endpackage

// File: rtl/pic_wr_edge_detect.sv
// pic_wr_edge_detect: optional bus register stage plus one-commit-per-pulse write detect
module pic_wr_edge_detect #(
  parameter bit BUS_SYNC = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  output logic       wr_commit,
  output logic       a0_q,
  output logic [7:0] din_q
);
  logic cs_s, wr_s, wr_prev;
  if (BUS_SYNC) begin : g_sync
    // register the CPU bus once before decode
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cs_s  <= 1'b1;
        wr_s  <= 1'b1;
        a0_q  <= 1'b0;
        din_q <= '0;
      end else begin
        cs_s  <= cs_n;
        wr_s  <= wr_n;
        a0_q  <= a0;
        din_q <= din;
      end
  end else begin : g_bypass
    assign cs_s  = cs_n;
    assign wr_s  = wr_n;
    assign a0_q  = a0;
    assign din_q = din;
  end
  // remember last sampled strobe so a long low pulse commits only once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_prev <= 1'b1;
    else wr_prev <= wr_s;
  assign wr_commit = !cs_s && !wr_s && wr_prev;
endmodule

// File: rtl/pic_command_sequencer.sv
// pic_command_sequencer: ICW/OCW decode, init sequencing and PIC configuration registers
module pic_command_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR   = 8,
  parameter bit BUS_SYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              wr_n,
  input  logic              a0,
  input  logic [7:0]        din,
  output logic [NUM_IR-1:0] imr,
  output logic [4:0]        vector_base,
  output logic [7:0]        cascade_cfg,
  output logic              ltim,
  output logic              single_mode,
  output logic              aeoi,
  output logic              rotate_aeoi,
  output logic              special_mask,
  output logic              read_isr,
  output logic              init_done,
  output logic              eoi_pulse,
  output logic              eoi_specific,
  output logic [2:0]        eoi_level,
  output logic              rotate_pulse,
  output logic              poll_pulse,
  output logic              cmd_error
);
  logic       commit, a0_q, ic4;
  logic [7:0] din_q;
  logic [2:0] code;
  state_t     state, state_nxt;
  logic       is_icw1, ld_icw2, ld_icw3, ld_icw4, ld_ocw1, ocw2, ocw3, err;
  pic_wr_edge_detect #(.BUS_SYNC(BUS_SYNC)) u_edge (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .wr_commit(commit), .a0_q(a0_q), .din_q(din_q)
  );
  assign code      = din_q[7:5];
  assign init_done = state == READY;
  // decode a committed write against the current init/operation state
  always_comb begin
    state_nxt = state;
    ld_icw2   = 1'b0;
    ld_icw3   = 1'b0;
    ld_icw4   = 1'b0;
    ld_ocw1   = 1'b0;
    ocw2      = 1'b0;
    ocw3      = 1'b0;
    err       = 1'b0;
    is_icw1   = commit && !a0_q && din_q[ICW1_BIT];
    if (is_icw1) state_nxt = WAIT_ICW2;
    else if (commit)
      case (state)
        WAIT_ICW2: begin
          ld_icw2   = a0_q;
          err       = !a0_q;
          state_nxt = !a0_q ? state : !single_mode ? WAIT_ICW3 : ic4 ? WAIT_ICW4 : READY;
        end
        WAIT_ICW3: begin
          ld_icw3   = a0_q;
          err       = !a0_q;
          state_nxt = !a0_q ? state : ic4 ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: begin
          ld_icw4   = a0_q;
          err       = !a0_q;
          state_nxt = a0_q ? READY : state;
        end
        READY: begin
          ld_ocw1 = a0_q;
          ocw2    = !a0_q && !din_q[3];
          ocw3    = !a0_q && din_q[3];
        end
        default: err = 1'b1;
      endcase
  end
  // state register, configuration registers and one-cycle command strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      imr          <= '0;
      vector_base  <= '0;
      cascade_cfg  <= '0;
      ltim         <= 1'b0;
      single_mode  <= 1'b0;
      ic4          <= 1'b0;
      aeoi         <= 1'b0;
      rotate_aeoi  <= 1'b0;
      special_mask <= 1'b0;
      read_isr     <= 1'b0;
      eoi_pulse    <= 1'b0;
      eoi_specific <= 1'b0;
      eoi_level    <= '0;
      rotate_pulse <= 1'b0;
      poll_pulse   <= 1'b0;
      cmd_error    <= 1'b0;
    end else begin
      state        <= state_nxt;
      eoi_pulse    <= ocw2 && code[0];
      eoi_specific <= ocw2 && (code == EOI_SP || code == ROT_EOI_SP);
      rotate_pulse <= ocw2 && (code == ROT_EOI_NS || code == ROT_EOI_SP || code == SET_PRI);
      poll_pulse   <= ocw3 && din_q[P_BIT];
      cmd_error    <= err;
      if (is_icw1) begin
        imr          <= '0;
        special_mask <= 1'b0;
        read_isr     <= 1'b0;
        aeoi         <= 1'b0;
        rotate_aeoi  <= 1'b0;
        ic4          <= din_q[IC4_BIT];
        single_mode  <= din_q[SNGL_BIT];
        ltim         <= din_q[LTIM_BIT];
      end
      if (ld_icw2) vector_base <= din_q[7:3];
      if (ld_icw3) cascade_cfg <= din_q;
      if (ld_icw4) aeoi <= din_q[AEOI_BIT];
      if (ld_ocw1) imr <= din_q[NUM_IR-1:0];
      if (ocw2) begin
        eoi_level <= din_q[2:0];
        if (code == ROT_AEOI_SET || code == ROT_AEOI_CLR) begin
          rotate_aeoi <= code[2];
          aeoi        <= code[2];
        end
      end
      if (ocw3 && din_q[RR_BIT]) read_isr <= din_q[RIS_BIT];
      if (ocw3 && din_q[ESMM_BIT]) special_mask <= din_q[SMM_BIT];
    end
endmodule

// File: tb/tb_pic_command_sequencer.sv
// tb_pic_command_sequencer: directed-vector checks of init sequencing, OCW decode and strobes
module tb_pic_command_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, cs_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] imr, cascade_cfg;
  logic [4:0] vector_base;
  logic [2:0] eoi_level;
  logic ltim, single_mode, aeoi, rotate_aeoi, special_mask, read_isr, init_done;
  logic eoi_pulse, eoi_specific, rotate_pulse, poll_pulse, cmd_error;
  int vec = 0, bad = 0;
  int n_eoi = 0, n_spec = 0, n_rot = 0, n_poll = 0, n_err = 0;

  pic_command_sequencer #(.NUM_IR(8), .BUS_SYNC(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
    .imr(imr), .vector_base(vector_base), .cascade_cfg(cascade_cfg), .ltim(ltim),
    .single_mode(single_mode), .aeoi(aeoi), .rotate_aeoi(rotate_aeoi),
    .special_mask(special_mask), .read_isr(read_isr), .init_done(init_done),
    .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .rotate_pulse(rotate_pulse), .poll_pulse(poll_pulse), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // count high cycles of every strobe; tasks compare deltas around each write
  always @(negedge clk) begin
    n_eoi  <= n_eoi + int'(eoi_pulse);
    n_spec <= n_spec + int'(eoi_specific);
    n_rot  <= n_rot + int'(rotate_pulse);
    n_poll <= n_poll + int'(poll_pulse);
    n_err  <= n_err + int'(cmd_error);
  end

  task automatic wr(input logic a, input logic [7:0] d, input int hold = 1);
    @(posedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
    repeat (hold) @(posedge clk);
    #1 wr_n = 1'b1; cs_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (imr !== 8'h00) begin bad++; $display("FAIL reset_imr got %h want 00", imr); end
    vec++; if ({init_done, read_isr, aeoi, vector_base} !== 8'h00) begin bad++; $display("FAIL reset_cfg got %b want 0", {init_done, read_isr, aeoi, vector_base}); end
    vec++; if ({eoi_pulse, rotate_pulse, poll_pulse, cmd_error} !== 4'b0) begin bad++; $display("FAIL reset_strobes got %b want 0000", {eoi_pulse, rotate_pulse, poll_pulse, cmd_error}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_idle_error();
    int e0 = n_err;
    wr(1'b1, 8'hFF);
    vec++; if (n_err - e0 !== 1) begin bad++; $display("FAIL idle_err got %0d want 1", n_err - e0); end
    vec++; if (imr !== 8'h00 || init_done !== 1'b0) begin bad++; $display("FAIL idle_state got imr=%h done=%b want 00/0", imr, init_done); end
  endtask

  task automatic test_init_single();
    wr(1'b0, 8'h13);
    wr(1'b1, 8'h48);
    vec++; if (init_done !== 1'b0) begin bad++; $display("FAIL single_done_early got %b want 0", init_done); end
    wr(1'b1, 8'h03);
    vec++; if (vector_base !== 5'h09) begin bad++; $display("FAIL single_vbase got %h want 09", vector_base); end
    vec++; if (aeoi !== 1'b1 || single_mode !== 1'b1) begin bad++; $display("FAIL single_mode_aeoi got %b%b want 11", aeoi, single_mode); end
    vec++; if (cascade_cfg !== 8'h00 || init_done !== 1'b1) begin bad++; $display("FAIL single_done got casc=%h done=%b want 00/1", cascade_cfg, init_done); end
  endtask

  task automatic test_init_cascade();
    int e0;
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h20);
    e0 = n_err;
    wr(1'b0, 8'h20);
    vec++; if (n_err - e0 !== 1) begin bad++; $display("FAIL casc_err got %0d want 1", n_err - e0); end
    vec++; if (init_done !== 1'b0 || single_mode !== 1'b0) begin bad++; $display("FAIL casc_mid got done=%b sngl=%b want 0/0", init_done, single_mode); end
    wr(1'b1, 8'h04);
    wr(1'b1, 8'h01);
    vec++; if (cascade_cfg !== 8'h04 || vector_base !== 5'h04) begin bad++; $display("FAIL casc_cfg got %h/%h want 04/04", cascade_cfg, vector_base); end
    vec++; if (init_done !== 1'b1 || aeoi !== 1'b0) begin bad++; $display("FAIL casc_done got done=%b aeoi=%b want 1/0", init_done, aeoi); end
  endtask

  task automatic test_ocw2();
    int e0 = n_eoi, s0 = n_spec, r0 = n_rot;
    wr(1'b0, 8'h63);
    vec++; if (n_eoi - e0 !== 1 || n_spec - s0 !== 1 || n_rot - r0 !== 0) begin bad++; $display("FAIL ocw2_eoi_sp got eoi=%0d spec=%0d rot=%0d want 1/1/0", n_eoi - e0, n_spec - s0, n_rot - r0); end
    vec++; if (eoi_level !== 3'd3) begin bad++; $display("FAIL ocw2_lvl3 got %0d want 3", eoi_level); end
    e0 = n_eoi; s0 = n_spec; r0 = n_rot;
    wr(1'b0, 8'hC5);
    vec++; if (n_eoi - e0 !== 0 || n_spec - s0 !== 0 || n_rot - r0 !== 1) begin bad++; $display("FAIL ocw2_setpri got eoi=%0d spec=%0d rot=%0d want 0/0/1", n_eoi - e0, n_spec - s0, n_rot - r0); end
    vec++; if (eoi_level !== 3'd5) begin bad++; $display("FAIL ocw2_lvl5 got %0d want 5", eoi_level); end
    e0 = n_eoi; r0 = n_rot;
    wr(1'b0, 8'hA1);
    vec++; if (n_eoi - e0 !== 1 || n_rot - r0 !== 1) begin bad++; $display("FAIL ocw2_rot_eoi got eoi=%0d rot=%0d want 1/1", n_eoi - e0, n_rot - r0); end
    e0 = n_eoi; r0 = n_rot;
    wr(1'b0, 8'h80);
    vec++; if (rotate_aeoi !== 1'b1 || n_eoi - e0 !== 0 || n_rot - r0 !== 0) begin bad++; $display("FAIL ocw2_rot_aeoi got ra=%b eoi=%0d rot=%0d want 1/0/0", rotate_aeoi, n_eoi - e0, n_rot - r0); end
  endtask

  task automatic test_ocw1_ocw3();
    int p0;
    wr(1'b1, 8'hA5);
    vec++; if (imr !== 8'hA5) begin bad++; $display("FAIL ocw1_imr got %h want a5", imr); end
    wr(1'b0, 8'h0B);
    vec++; if (read_isr !== 1'b1) begin bad++; $display("FAIL ocw3_ris got %b want 1", read_isr); end
    p0 = n_poll;
    wr(1'b0, 8'h6C);
    vec++; if (special_mask !== 1'b1 || read_isr !== 1'b1) begin bad++; $display("FAIL ocw3_smm got smm=%b ris=%b want 1/1", special_mask, read_isr); end
    vec++; if (n_poll - p0 !== 1) begin bad++; $display("FAIL ocw3_poll got %0d want 1", n_poll - p0); end
  endtask

  task automatic test_back_to_back();
    int e0 = n_eoi, r0 = n_err;
    wr(1'b0, 8'h20, 10);
    vec++; if (n_eoi - e0 !== 1) begin bad++; $display("FAIL long_wr_eoi got %0d want 1", n_eoi - e0); end
    wr(1'b0, 8'h13, 10);
    vec++; if (imr !== 8'h00 || init_done !== 1'b0) begin bad++; $display("FAIL reinit got imr=%h done=%b want 00/0", imr, init_done); end
    vec++; if (special_mask !== 1'b0 || read_isr !== 1'b0 || n_err - r0 !== 0) begin bad++; $display("FAIL reinit_clr got smm=%b ris=%b err=%0d want 0/0/0", special_mask, read_isr, n_err - r0); end
  endtask

  task automatic test_mid_reset();
    wr(1'b1, 8'h48);
    @(posedge clk); #1 rst_n = 1'b0;
    #2;
    vec++; if (vector_base !== 5'h00 || init_done !== 1'b0) begin bad++; $display("FAIL midrst got vb=%h done=%b want 00/0", vector_base, init_done); end
    #5 rst_n = 1'b1;
    wr(1'b1, 8'h48);
    vec++; if (vector_base !== 5'h00) begin bad++; $display("FAIL midrst_lost got %h want 00", vector_base); end
  endtask

  initial begin
    test_reset();
    test_idle_error();
    test_init_single();
    test_init_cascade();
    test_ocw2();
    test_ocw1_ocw3();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
